// File: rtl/nfault_line_arbiter.sv
// Round-robin arbiter for the shared open-drain nFault line: queues per-unit
// requests, drives the line low for a minimum hold, and keeps sticky fault status.
module nfault_line_arbiter #(
   parameter int NUM_UNITS   = 4,
   parameter int HOLD_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_UNITS-1:0] set_nFault_value,
   input  logic [NUM_UNITS-1:0] set_nFault_z,
   input  logic [NUM_UNITS-1:0] unit_fault,
   input  logic                 clear_fault,
   output logic                 nFault_oe,
   output logic                 nFault_out,
   output logic [3:0]           owner_id,
   output logic                 line_busy,
   output logic [NUM_UNITS-1:0] fault_source,
   output logic [7:0]           fault_count
);

   localparam int IDX_W = $clog2(NUM_UNITS);
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GRANT   = 3'd1,
      S_DRIVE   = 3'd2,
      S_HOLD    = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t               state, state_d;
   logic [NUM_UNITS-1:0] pending, pending_d;
   logic [3:0]           last_grant;
   logic [CNT_W-1:0]     hold_cnt, hold_d;
   logic [IDX_W-1:0]     scan_idx, grant_idx, owner_idx;
   logic                 found, grant;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign nFault_out = 1'b0;
   assign owner_idx  = owner_id[IDX_W-1:0];

   // Round-robin scan starting just after the last granted unit.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int k = 1; k <= NUM_UNITS; k++) begin
         scan_idx = IDX_W'((int'(last_grant) + k) % NUM_UNITS);
         if (!found && pending[scan_idx]) begin
            found     = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   // DRIVE runs while hold_cnt counts down to 1; the HOLD cycle completes the
   // minimum pulse, so a unit that drops its fault at once is low exactly HOLD_CYCLES.
   always_comb begin
      state_d = state;
      hold_d  = hold_cnt;
      grant   = 1'b0;
      case (state)
         S_IDLE:
            if (found) begin
               state_d = S_GRANT;
               grant   = 1'b1;
            end
         S_GRANT:
            if (unit_fault[owner_idx]) begin
               state_d = (HOLD_CYCLES == 1) ? S_HOLD : S_DRIVE;
               hold_d  = CNT_W'(HOLD_CYCLES - 1);
            end else begin
               state_d = S_RELEASE;
            end
         S_DRIVE: begin
            if (hold_cnt != '0)
               hold_d = hold_cnt - 1'b1;
            if (hold_cnt <= CNT_W'(1))
               state_d = S_HOLD;
         end
         S_HOLD:
            if (!unit_fault[owner_idx] || clear_fault || set_nFault_z[owner_idx])
               state_d = S_RELEASE;
         S_RELEASE:
            state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pending_d = (pending | set_nFault_value) & ~set_nFault_z;
      if (grant)
         pending_d[grant_idx] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         pending      <= '0;
         last_grant   <= 4'(NUM_UNITS - 1);
         owner_id     <= '0;
         hold_cnt     <= '0;
         nFault_oe    <= 1'b0;
         line_busy    <= 1'b0;
         fault_source <= '0;
         fault_count  <= '0;
      end else begin
         state     <= state_d;
         pending   <= pending_d;
         hold_cnt  <= hold_d;
         nFault_oe <= (state_d == S_DRIVE) || (state_d == S_HOLD);
         line_busy <= (state_d != S_IDLE);
         if (grant) begin
            owner_id   <= 4'(grant_idx);
            last_grant <= 4'(grant_idx);
         end
         // A clear in the same cycle as a new fault wins.
         if (clear_fault) begin
            fault_source <= '0;
            fault_count  <= '0;
         end else if (state == S_GRANT && unit_fault[owner_idx]) begin
            fault_source[owner_idx] <= 1'b1;
            fault_count             <= sat_inc(fault_count);
         end
      end
   end

endmodule
